// File: rtl/nios_debug_scan_channel.sv
// nios_debug_scan_channel
//   Debug scan-chain controller for the Nios debug module. An IR selects one of NUM_CH data
//   registers (codes >= NUM_CH select a 1-bit bypass register). Capture/shift/update strobes
//   from the oversampled JTAG state machine operate on the selected channel's length. Each
//   completed update is handed to the core side over a valid/ready command port.
//
// Ports
//   clk, reset                   rising-edge clock, asynchronous active-high reset
//   ena                          node enable, gates all four strobes
//   ir_in, st_update_ir          IR value and its load strobe
//   st_capture, st_shift,
//   st_update_dr                 DR strobes, at most one acted on per cycle
//   tdi / tdo                    serial in (sampled with st_shift) / serial out (sr[0])
//   cap_data                     per-channel capture values, ch k at [DR_W*k +: DR_W]
//   cmd_valid, cmd_ready         command handshake
//   cmd_ch, cmd_data, cmd_bits,
//   cmd_len_err                  command payload (channel, data, bit count, length mismatch)
//   overrun, overrun_clr         sticky dropped-update flag and its clear
//   ir_q                         current IR
module nios_debug_scan_channel #(
    parameter int unsigned          IR_W   = 2,
    parameter int unsigned          NUM_CH = 4,
    parameter int unsigned          DR_W   = 38,
    parameter logic [8*NUM_CH-1:0]  CH_LEN = {NUM_CH{8'd38}}
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ena,
    input  logic [IR_W-1:0]        ir_in,
    input  logic                   st_update_ir,
    input  logic                   st_capture,
    input  logic                   st_shift,
    input  logic                   st_update_dr,
    input  logic                   tdi,
    output logic                   tdo,
    input  logic [NUM_CH*DR_W-1:0] cap_data,
    output logic                   cmd_valid,
    input  logic                   cmd_ready,
    output logic [IR_W-1:0]        cmd_ch,
    output logic [DR_W-1:0]        cmd_data,
    output logic [7:0]             cmd_bits,
    output logic                   cmd_len_err,
    output logic                   overrun,
    input  logic                   overrun_clr,
    output logic [IR_W-1:0]        ir_q
);

    typedef enum logic [1:0] {StIdle, StCap, StShift} state_e;

    state_e          st_q, st_d;
    logic [DR_W-1:0] sr_q, sr_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [IR_W-1:0] ir_d;

    logic            cmd_valid_d;
    logic [IR_W-1:0] cmd_ch_d;
    logic [DR_W-1:0] cmd_data_d;
    logic [7:0]      cmd_bits_d;
    logic            cmd_len_err_d;
    logic            overrun_d;

    logic            ch_valid;
    logic [7:0]      len_act;
    logic [DR_W-1:0] sel_cap;
    logic [DR_W-1:0] len_mask;
    logic [DR_W-1:0] sr_up;
    logic [DR_W-1:0] sr_shift;
    logic [7:0]      cnt_inc;
    logic            issue;
    logic            accept;

    assign tdo = sr_q[0];

    // Channel decode: active length, capture source and bypass detection.
    always_comb begin
        ch_valid = 1'b0;
        len_act  = 8'd1;
        sel_cap  = '0;
        for (int k = 0; k < int'(NUM_CH); k++) begin
            if (ir_q == IR_W'(k)) begin
                ch_valid = 1'b1;
                len_act  = CH_LEN[8*k +: 8];
                sel_cap  = cap_data[DR_W*k +: DR_W];
            end
        end
        if (len_act == 8'd0) begin
            len_act = 8'd1;
        end
    end

    // Shifting happens inside the active length only; tdi enters at bit L-1 and
    // everything at or above L stays zero.
    always_comb begin
        sr_up = {1'b0, sr_q[DR_W-1:1]};
        for (int i = 0; i < int'(DR_W); i++) begin
            len_mask[i] = (i < int'(len_act));
            sr_shift[i] = 1'b0;
            if (i == int'(len_act) - 1) begin
                sr_shift[i] = tdi;
            end else if (i < int'(len_act) - 1) begin
                sr_shift[i] = sr_up[i];
            end
        end
        cnt_inc = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;
    end

    // Scan FSM: one strobe per cycle, priority update_ir > update_dr > capture > shift.
    always_comb begin
        st_d  = st_q;
        sr_d  = sr_q;
        cnt_d = cnt_q;
        ir_d  = ir_q;
        issue = 1'b0;
        if (ena) begin
            if (st_update_ir) begin
                ir_d = ir_in;
                sr_d = '0;
                st_d = StIdle;
            end else if (st_update_dr) begin
                issue = (st_q == StShift) && ch_valid;
                st_d  = StIdle;
            end else if (st_capture) begin
                // Capture during SHIFT would clobber in-flight data.
                if (st_q != StShift) begin
                    sr_d  = ch_valid ? (sel_cap & len_mask) : '0;
                    cnt_d = 8'd0;
                    st_d  = StCap;
                end
            end else if (st_shift) begin
                sr_d = sr_shift;
                if (st_q != StIdle) begin
                    cnt_d = cnt_inc;
                    st_d  = StShift;
                end
            end
        end
    end

    // Command port: a new update loads only into an empty or just-accepted slot.
    always_comb begin
        cmd_valid_d   = cmd_valid;
        cmd_ch_d      = cmd_ch;
        cmd_data_d    = cmd_data;
        cmd_bits_d    = cmd_bits;
        cmd_len_err_d = cmd_len_err;
        overrun_d     = overrun;
        accept        = cmd_valid & cmd_ready;
        if (overrun_clr) begin
            overrun_d = 1'b0;
        end
        if (issue) begin
            if (!cmd_valid || cmd_ready) begin
                cmd_valid_d   = 1'b1;
                cmd_ch_d      = ir_q;
                cmd_data_d    = sr_q;
                cmd_bits_d    = cnt_q;
                cmd_len_err_d = (cnt_q != len_act);
            end else begin
                overrun_d = 1'b1;
            end
        end else if (accept) begin
            cmd_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q        <= StIdle;
            sr_q        <= '0;
            cnt_q       <= 8'd0;
            ir_q        <= '0;
            cmd_valid   <= 1'b0;
            cmd_ch      <= '0;
            cmd_data    <= '0;
            cmd_bits    <= 8'd0;
            cmd_len_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            st_q        <= st_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            ir_q        <= ir_d;
            cmd_valid   <= cmd_valid_d;
            cmd_ch      <= cmd_ch_d;
            cmd_data    <= cmd_data_d;
            cmd_bits    <= cmd_bits_d;
            cmd_len_err <= cmd_len_err_d;
            overrun     <= overrun_d;
        end
    end

endmodule

// File: tb/tb_nios_debug_scan_channel.sv
// Testbench for nios_debug_scan_channel: two instances (4 channels with lengths 0/38/5/16, and
// 3 channels with lengths 12/38/8 so IR code 3 is bypass) driven with shared stimulus.
module tb_nios_debug_scan_channel;

    logic         clk = 1'b0;
    logic         reset;
    logic         ena;
    logic [1:0]   ir_in;
    logic         st_update_ir, st_capture, st_shift, st_update_dr;
    logic         tdi;
    logic         cmd_ready;
    logic         overrun_clr;
    logic [151:0] cap_a;
    logic [113:0] cap_b;

    logic [1:0]       tdo, cmd_valid, cmd_len_err, overrun;
    logic [1:0][1:0]  cmd_ch, ir_q;
    logic [1:0][37:0] cmd_data;
    logic [1:0][7:0]  cmd_bits;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;
    assign cap_b = cap_a[113:0];

    nios_debug_scan_channel #(
        .IR_W(2), .NUM_CH(4), .DR_W(38), .CH_LEN({8'd16, 8'd5, 8'd38, 8'd0})
    ) dut_a (
        .clk(clk), .reset(reset), .ena(ena), .ir_in(ir_in),
        .st_update_ir(st_update_ir), .st_capture(st_capture), .st_shift(st_shift),
        .st_update_dr(st_update_dr), .tdi(tdi), .tdo(tdo[0]), .cap_data(cap_a),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready), .cmd_ch(cmd_ch[0]),
        .cmd_data(cmd_data[0]), .cmd_bits(cmd_bits[0]), .cmd_len_err(cmd_len_err[0]),
        .overrun(overrun[0]), .overrun_clr(overrun_clr), .ir_q(ir_q[0])
    );

    nios_debug_scan_channel #(
        .IR_W(2), .NUM_CH(3), .DR_W(38), .CH_LEN({8'd8, 8'd38, 8'd12})
    ) dut_b (
        .clk(clk), .reset(reset), .ena(ena), .ir_in(ir_in),
        .st_update_ir(st_update_ir), .st_capture(st_capture), .st_shift(st_shift),
        .st_update_dr(st_update_dr), .tdi(tdi), .tdo(tdo[1]), .cap_data(cap_b),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready), .cmd_ch(cmd_ch[1]),
        .cmd_data(cmd_data[1]), .cmd_bits(cmd_bits[1]), .cmd_len_err(cmd_len_err[1]),
        .overrun(overrun[1]), .overrun_clr(overrun_clr), .ir_q(ir_q[1])
    );

    // ---------------- reference model ----------------
    // Phase: 0 = no capture yet, 1 = captured, 2 = at least one bit shifted since capture.
    logic [37:0] m_sr [2];
    int          m_ir [2], m_cnt [2], m_ph [2], m_ch [2], m_bits [2];
    logic        m_cv [2], m_err [2], m_ov [2];
    logic [37:0] m_data [2];

    function automatic int nch(input int d);
        return (d == 0) ? 4 : 3;
    endfunction

    function automatic int lenf(input int d, input int ir);
        int v;
        if (ir >= nch(d)) return 1;
        if (d == 0) begin
            case (ir)
                0: v = 0;
                1: v = 38;
                2: v = 5;
                default: v = 16;
            endcase
        end else begin
            case (ir)
                0: v = 12;
                1: v = 38;
                default: v = 8;
            endcase
        end
        return (v == 0) ? 1 : v;
    endfunction

    function automatic logic [37:0] lmask(input int l);
        logic [63:0] one = 64'd1;
        return 38'((one << l) - 64'd1);
    endfunction

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            int   l;
            logic valid, issue, set_ov;
            if (reset) begin
                m_sr[d] = '0; m_ir[d] = 0; m_cnt[d] = 0; m_ph[d] = 0; m_ch[d] = 0;
                m_bits[d] = 0; m_cv[d] = 0; m_err[d] = 0; m_ov[d] = 0; m_data[d] = '0;
                continue;
            end
            l      = lenf(d, m_ir[d]);
            valid  = (m_ir[d] < nch(d));
            issue  = 1'b0;
            set_ov = 1'b0;
            if (ena) begin
                if (st_update_ir) begin
                    m_ir[d] = int'(ir_in); m_sr[d] = '0; m_ph[d] = 0;
                end else if (st_update_dr) begin
                    issue = (m_ph[d] == 2) && valid; m_ph[d] = 0;
                end else if (st_capture) begin
                    if (m_ph[d] != 2) begin
                        m_sr[d]  = valid ? (cap_a[38*m_ir[d] +: 38] & lmask(l)) : '0;
                        m_cnt[d] = 0;
                        m_ph[d]  = 1;
                    end
                end else if (st_shift) begin
                    m_sr[d] = m_sr[d] >> 1;
                    m_sr[d][l-1] = tdi;
                    if (m_ph[d] != 0) begin
                        m_cnt[d] = (m_cnt[d] >= 255) ? 255 : m_cnt[d] + 1;
                        m_ph[d]  = 2;
                    end
                end
            end
            if (issue) begin
                if (!m_cv[d] || cmd_ready) begin
                    m_cv[d] = 1'b1; m_ch[d] = m_ir[d]; m_data[d] = m_sr[d];
                    m_bits[d] = m_cnt[d]; m_err[d] = (m_cnt[d] != l);
                end else begin
                    set_ov = 1'b1;
                end
            end else if (m_cv[d] && cmd_ready) begin
                m_cv[d] = 1'b0;
            end
            if (set_ov) m_ov[d] = 1'b1;
            else if (overrun_clr) m_ov[d] = 1'b0;
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            logic [63:0] got, exp;
            got = 64'({tdo[d], cmd_valid[d], cmd_ch[d], cmd_data[d], cmd_bits[d],
                       cmd_len_err[d], overrun[d], ir_q[d]});
            exp = 64'({m_sr[d][0], m_cv[d], 2'(m_ch[d]), m_data[d], 8'(m_bits[d]),
                       m_err[d], m_ov[d], 2'(m_ir[d])});
            chk(d == 0 ? "model_a" : "model_b", got, exp);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
        st_update_ir = 1'b0; st_capture = 1'b0; st_shift = 1'b0; st_update_dr = 1'b0;
        overrun_clr  = 1'b0;
    endtask

    function automatic logic [151:0] rand_cap();
        return 152'({$urandom, $urandom, $urandom, $urandom, $urandom});
    endfunction

    // IR load, capture with 'cap' on channel ir, nsh shifts of constant t; records tdo of dut d.
    task automatic scan_pre(input int d, input int ir, input logic [37:0] cap, input int nsh,
                            input logic t, output logic [319:0] strm);
        strm = '0;
        ir_in = 2'(ir); st_update_ir = 1'b1; tick();
        cap_a = rand_cap(); cap_a[38*ir +: 38] = cap; st_capture = 1'b1; tick();
        tdi = t;
        for (int i = 0; i < nsh; i++) begin
            strm[i] = tdo[d];
            st_shift = 1'b1; tick();
        end
    endtask

    task automatic upd();
        st_update_dr = 1'b1; tick();
    endtask

    typedef struct {
        int          d;
        int          ir;
        logic [37:0] cap;
        int          nsh;
        logic        t;
        logic [37:0] e_data;
        int          e_bits;
        logic        e_err;
    } vec_t;

    vec_t tbl [6];

    initial begin
        logic [319:0] strm, e_strm;
        logic [37:0]  cm;
        int           l;

        tbl[0] = '{0, 1, 38'h15_5555_5555, 38,  1'b1, 38'h3F_FFFF_FFFF, 38,  1'b0};
        tbl[1] = '{0, 3, 38'h0_0000_ABCD,  10,  1'b0, 38'h0_0000_002A,  10,  1'b1};
        tbl[2] = '{0, 0, 38'h0_0000_0002,  1,   1'b1, 38'h0_0000_0001,  1,   1'b0};
        tbl[3] = '{0, 2, 38'h0_0000_03FF,  3,   1'b0, 38'h0_0000_0003,  3,   1'b1};
        tbl[4] = '{1, 1, 38'h2A_1234_5678, 300, 1'b1, 38'h3F_FFFF_FFFF, 255, 1'b1};
        tbl[5] = '{1, 2, 38'h0_0000_FF5A,  8,   1'b0, 38'h0_0000_0000,  8,   1'b0};

        reset = 1'b1; ena = 1'b1; ir_in = '0; tdi = 1'b0; cmd_ready = 1'b1;
        overrun_clr = 1'b0; cap_a = '0;
        st_update_ir = 1'b0; st_capture = 1'b0; st_shift = 1'b0; st_update_dr = 1'b0;
        tick();
        chk("reset_state", 64'({tdo, cmd_valid, cmd_data, cmd_bits, overrun, ir_q}), 64'd0);
        reset = 1'b0;
        tick();

        // Table-driven full scans with the consumer always ready.
        for (int v = 0; v < 6; v++) begin
            int d;
            d = tbl[v].d;
            scan_pre(d, tbl[v].ir, tbl[v].cap, tbl[v].nsh, tbl[v].t, strm);
            l  = lenf(d, tbl[v].ir);
            cm = tbl[v].cap & lmask(l);
            e_strm = '0;
            for (int i = 0; i < tbl[v].nsh; i++) e_strm[i] = (i < l) ? cm[i] : tbl[v].t;
            chk($sformatf("tdo_stream_%0d", v), 64'(strm ^ e_strm), 64'd0);
            upd();
            chk($sformatf("cmd_valid_%0d", v), 64'(cmd_valid[d]), 64'd1);
            chk($sformatf("cmd_ch_%0d", v), 64'(cmd_ch[d]), 64'(tbl[v].ir));
            chk($sformatf("cmd_data_%0d", v), 64'(cmd_data[d]), 64'(tbl[v].e_data));
            chk($sformatf("cmd_bits_%0d", v), 64'(cmd_bits[d]), 64'(tbl[v].e_bits));
            chk($sformatf("cmd_len_err_%0d", v), 64'(cmd_len_err[d]), 64'(tbl[v].e_err));
        end
        tick(); // drain

        // Back-pressure: second update dropped, overrun set, first command held.
        cmd_ready = 1'b0;
        scan_pre(0, 3, 38'h1234, 4, 1'b1, strm); upd();
        scan_pre(0, 3, 38'h5555, 16, 1'b0, strm); upd();
        chk("bp_valid", 64'(cmd_valid[0]), 64'd1);
        chk("bp_data", 64'(cmd_data[0]), 64'h0F123);
        chk("bp_overrun", 64'(overrun[0]), 64'd1);
        chk("bypass_no_overrun", 64'(overrun[1]), 64'd0);
        overrun_clr = 1'b1; tick();
        chk("overrun_clr", 64'(overrun[0]), 64'd0);

        // Accept and reload in the same cycle.
        scan_pre(0, 3, 38'h00FF, 4, 1'b0, strm);
        cmd_ready = 1'b1; upd();
        chk("reload_valid", 64'(cmd_valid[0]), 64'd1);
        chk("reload_data", 64'(cmd_data[0]), 64'h000F);
        chk("reload_overrun", 64'(overrun[0]), 64'd0);
        tick();
        chk("accept_clears", 64'(cmd_valid[0]), 64'd0);
        chk("accept_holds", 64'(cmd_data[0]), 64'h000F);

        // Bypass on dut_b: 1-bit register, capture in SHIFT ignored, no command.
        scan_pre(1, 3, 38'h3F_FFFF_FFFF, 0, 1'b0, strm);
        chk("byp_cap", 64'(tdo[1]), 64'd0);
        tdi = 1'b1; st_shift = 1'b1; tick();
        chk("byp_sh1", 64'(tdo[1]), 64'd1);
        tdi = 1'b0; st_shift = 1'b1; tick();
        chk("byp_sh2", 64'(tdo[1]), 64'd0);
        tdi = 1'b1; st_shift = 1'b1; tick();
        st_capture = 1'b1; tick();
        chk("cap_in_shift_ignored", 64'(tdo[1]), 64'd1);
        upd();
        chk("byp_no_cmd", 64'(cmd_valid[1]), 64'd0);

        // Reset mid-shift with a command pending.
        cmd_ready = 1'b0;
        scan_pre(0, 2, 38'h15, 2, 1'b1, strm); upd();
        scan_pre(0, 1, 38'h3F_0F0F_0F0F, 5, 1'b1, strm);
        reset = 1'b1; tick();
        chk("rst_mid_a", 64'({tdo[0], cmd_valid[0], cmd_data[0], cmd_bits[0], overrun[0],
                             ir_q[0]}), 64'd0);
        reset = 1'b0; tick();

        // update_ir beats update_dr in the same cycle.
        scan_pre(0, 1, 38'h3, 3, 1'b1, strm);
        ir_in = 2'd2; st_update_ir = 1'b1; st_update_dr = 1'b1; tick();
        chk("prio_ir", 64'(ir_q[0]), 64'd2);
        chk("prio_no_cmd", 64'(cmd_valid[0]), 64'd0);

        // Randomised traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            int r;
            r = int'($urandom_range(0, 99));
            reset        = ($urandom_range(0, 499) == 0);
            ena          = ($urandom_range(0, 9) != 0);
            ir_in        = 2'($urandom);
            tdi          = 1'($urandom);
            cmd_ready    = 1'($urandom);
            overrun_clr  = ($urandom_range(0, 19) == 0);
            cap_a        = rand_cap();
            st_update_ir = (r < 4);
            st_update_dr = (r >= 4 && r < 10);
            st_capture   = (r >= 10 && r < 18);
            st_shift     = (r >= 18 && r < 80);
            if ($urandom_range(0, 9) == 0) begin
                {st_update_ir, st_update_dr, st_capture, st_shift} =
                    {st_update_ir, st_update_dr, st_capture, st_shift} | 4'($urandom);
            end
            tick();
        end
        reset = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
